uart_click_tx: RTL
==================

# uart_click_tx

Remote-player click transmitter for two-board play. It lives on the second board and drives the inter-board wire whose far end feeds `uart_click_rx` on JB0 of the main board. Each synchronized local click pulse becomes one 8N1 UART frame carrying a fixed click byte. A small saturating pending-click counter holds clicks that arrive while a frame is in flight, so none are lost.

## Interface
- `CLK_FREQ`, default 65_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate.
- `CLICK_BYTE`, default 8'hA5: payload sent per click.
- `QUEUE_MAX`, default 7: saturation value of the pending counter, range 1..7.
- Derived `BIT_CYC = CLK_FREQ / BAUD` (integer truncation; 564 at defaults). It must be ≥ 2 and is checked at elaboration.

Ports:
- `clk`  in  1  system clock (65 MHz pixel clock domain).
- `rst`  in  1  asynchronous, active-low reset.
- `click_pulse`  in  1  single-cycle click event, already synchronous to `clk` (output of `mouse_sync`).
- `tx_out`  out  1  UART line, idle high, registered.
- `busy`  out  1  high while a frame is on the line (state ≠ IDLE).
- `pending_cnt`  out  3  clicks queued but not yet started.
- `dropped`  out  1  one-cycle pulse when a click is lost to saturation.

## Operation
- **States:** IDLE, START, DATA, STOP. A bit-cycle counter (0..BIT_CYC-1) and a bit index (0..7) drive the sequencing.
- **IDLE:**
  - `tx_out` = 1.
  - If `pending_cnt` > 0, go to START, decrement `pending_cnt`, and latch `CLICK_BYTE` into the shift register.
- **START:** `tx_out` = 0 for BIT_CYC cycles, then go to DATA with bit index 0.
- **DATA:** `tx_out` = shift register bit 0 (LSB first) for BIT_CYC cycles per bit. Shift right after each bit. After bit 7, go to STOP.
- **STOP:** `tx_out` = 1 for BIT_CYC cycles. On the last STOP cycle:
  - if `pending_cnt` > 0, go directly to START and decrement (back-to-back frames);
  - otherwise go to IDLE.
- **Pending counter:**
  - +1 on `click_pulse`.
  - −1 on frame accept (the IDLE→START or STOP→START transition).
  - Click and accept in the same cycle: value unchanged.
  - At `QUEUE_MAX` with a click and no accept: value holds and `dropped` = 1 for that cycle.
  - The counter never wraps and never underflows.
- `CLICK_BYTE` is constant. The shift register exists so that the payload can later be parameterized per frame without changing the timing.

## Timing
- **Reset values:** `tx_out` = 1, `busy` = 0, `pending_cnt` = 0, `dropped` = 0, state IDLE, counters 0. These take effect asynchronously on `rst` falling.
- **Latency:** `click_pulse` high in cycle c, from IDLE with count 0:
  - `pending_cnt` = 1 in cycle c+1;
  - `tx_out` = 0 and `busy` = 1 from cycle c+2;
  - `pending_cnt` back to 0 in cycle c+2.
- **Frame length:** exactly 10·BIT_CYC cycles from the first start-bit cycle to the last stop-bit cycle.
- **Back-to-back frames:** pitch is exactly 10·BIT_CYC cycles, with no extra idle cycle between them.
- `busy` falls in the cycle after the last stop-bit cycle when nothing is pending.
- **Reset mid-frame:** the line returns high immediately and the queue is cleared. After release, the FSM waits in IDLE for a new click; no partial frame is resumed.
- **Reset release:** synchronous to `clk` at the integrating level. The block itself treats `rst` purely as asynchronous.

## Test plan
Unless stated otherwise, tests override `CLK_FREQ`=1000 and `BAUD`=100, giving BIT_CYC=10.

1. **Single click:** one pulse at cycle 5 → `tx_out` low in cycles 7..16. Data bits of 8'hA5, LSB first (1,0,1,0,0,1,0,1), follow at 10 cycles each. Stop bit is high in cycles 97..106. `busy` falls at cycle 107.
2. **Back-to-back:** 3 pulses spaced 2 cycles apart while idle → three frames, start bits beginning 100 cycles apart. `pending_cnt` follows 1,2,…, then decrements at each frame start and reaches 0 at the third start.
3. **Saturation:** 10 pulses during one frame with `QUEUE_MAX`=7 → `pending_cnt` stops at 7, `dropped` pulses on 3 clicks, and exactly 8 frames total are sent.
4. **Simultaneous click and accept:** a click on the last STOP cycle with count 2 → count stays 2 and the next start bit begins the following cycle.
5. **Reset mid-frame:** `rst` low during the DATA stage with count 3 → `tx_out` = 1, `busy` = 0, `pending_cnt` = 0 in the same cycle; no traffic after release until a new click.
6. **Loopback at defaults:** 65 MHz / 115200 driving `uart_click_rx` with 20 random-spaced clicks → exactly 20 `click_pulse` outputs on the receiver.

Source files
------------

// File: rtl/uart_click_tx.sv
// Click transmitter: each click_pulse queues one 8N1 UART frame carrying CLICK_BYTE.
// A saturating pending counter holds clicks that arrive while a frame is on the line.
module uart_click_tx #(
    parameter int unsigned CLK_FREQ   = 65_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter logic [7:0]  CLICK_BYTE = 8'hA5,
    parameter int unsigned QUEUE_MAX  = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       click_pulse,
    output logic       tx_out,
    output logic       busy,
    output logic [2:0] pending_cnt,
    output logic       dropped
);

    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
    localparam int unsigned CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] LAST  = CW'(BIT_CYC - 1);
    localparam logic [2:0]    QMAX  = 3'(QUEUE_MAX);

    generate
        if (BIT_CYC < 2) begin : g_bad_bit_cyc
            $error("uart_click_tx: CLK_FREQ/BAUD must be at least 2");
        end
        if (QUEUE_MAX < 1 || QUEUE_MAX > 7) begin : g_bad_queue_max
            $error("uart_click_tx: QUEUE_MAX must be in 1..7");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cyc_cnt, cyc_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic          accept;
    logic          bit_done;

    assign bit_done = (cyc_cnt == LAST);
    assign busy     = (state != IDLE);

    always_comb begin
        state_n   = state;
        cyc_cnt_n = cyc_cnt + CW'(1);
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                cyc_cnt_n = '0;
                if (pending_cnt != '0) begin
                    accept  = 1'b1;
                    state_n = START;
                    shreg_n = CLICK_BYTE;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n   = DATA;
                    cyc_cnt_n = '0;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cyc_cnt_n = '0;
                    shreg_n   = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cyc_cnt_n = '0;
                    if (pending_cnt != '0) begin
                        accept  = 1'b1;
                        state_n = START;
                        shreg_n = CLICK_BYTE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // tx_out is registered from the next-state view so the line level lines up with busy.
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    assign dropped = click_pulse && !accept && (pending_cnt == QMAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_out  <= 1'b1;
        end else begin
            state   <= state_n;
            cyc_cnt <= cyc_cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx_out  <= tx_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_cnt <= '0;
        end else if (click_pulse && !accept) begin
            if (pending_cnt != QMAX) pending_cnt <= pending_cnt + 3'd1;
        end else if (!click_pulse && accept) begin
            pending_cnt <= pending_cnt - 3'd1;
        end
    end

endmodule
